// File: rtl/r_mem_reader_pkg.sv
// Shared types and default configuration for the constant-ROM read sequencer.
// Holds the burst state encoding and the FIFO sizing rule checked at elaboration.
package r_mem_reader_pkg;

    localparam int DEF_ADDR_WIDTH = 7;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_RD_LATENCY = 2;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Every read in flight must have a guaranteed FIFO slot, plus one for the word on the output.
    function automatic bit fifo_depth_ok(input int depth, input int rd_latency);
        return depth >= rd_latency + 1;
    endfunction

endpackage

// File: rtl/r_mem_reader_fifo.sv
// Small synchronous skid FIFO between the ROM pipeline and the output stream.
// Push and pop may coincide at any fill level; the head reads as zero while empty.
module r_mem_reader_fifo
    import r_mem_reader_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_WIDTH + 1,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             push_data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             head_data_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);
    localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] store_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_ONE;
    endfunction

    assign empty_o     = (count_q == '0);
    assign full        = (count_q == FULL_COUNT);
    assign do_pop      = pop_i && !empty_o;
    assign do_push     = push_i && (!full || do_pop);
    assign count_o     = count_q;
    assign head_data_o = empty_o ? '0 : store_q[rd_ptr_q];

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the count alone defines validity and the head is masked while empty.
    always_ff @(posedge clock) begin
        if (do_push) store_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/r_mem_reader.sv
// Read-side sequencer for the constant ROMs: issues a burst of addresses, absorbs the ROM latency
// and streams words out with lossless, credit-limited backpressure. Define R_MEM_READER_REVERSE_EN for descending order.
module r_mem_reader
    import r_mem_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int RD_LATENCY = DEF_RD_LATENCY,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   word_count,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);

    if (!fifo_depth_ok(FIFO_DEPTH, RD_LATENCY)) begin : g_depth_check
        $error("r_mem_reader: FIFO_DEPTH must be at least RD_LATENCY+1");
    end

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH:0]     count_q, count_d;
    logic [ADDR_WIDTH:0]     issued_q, issued_d;
    logic [ADDR_WIDTH:0]     pushed_q, pushed_d;
    logic [RD_LATENCY-1:0]   in_flight_q, in_flight_d;

    logic [ADDR_WIDTH-1:0]   start_addr;
    logic [ADDR_WIDTH-1:0]   addr_step;
    logic                    issue;
    logic                    push;
    logic                    push_last;
    logic                    pop;
    logic                    fifo_empty;
    logic [CW-1:0]           fifo_count;
    logic [DATA_WIDTH:0]     fifo_head;
    int                      credits_used;
    logic                    credit_ok;

`ifdef R_MEM_READER_REVERSE_EN
    assign start_addr = base_addr + word_count[ADDR_WIDTH-1:0] - ADDR_ONE;
    assign addr_step  = addr_q - ADDR_ONE;
`else
    assign start_addr = base_addr;
    assign addr_step  = addr_q + ADDR_ONE;
`endif

    // Tail of the in-flight pipe marks the cycle the ROM output holds the word issued RD_LATENCY cycles ago.
    assign push         = in_flight_q[RD_LATENCY-1];
    assign push_last    = (pushed_q == count_q - CNT_ONE);
    assign pop          = out_valid && out_ready;
    assign credits_used = $countones(in_flight_q) + int'(fifo_count);
    assign credit_ok    = (credits_used < FIFO_DEPTH);

    assign mem_addr  = addr_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign out_valid = !fifo_empty;
    assign out_data  = fifo_head[DATA_WIDTH-1:0];
    assign out_last  = fifo_head[DATA_WIDTH];

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        count_d     = count_q;
        issued_d    = issued_q;
        pushed_d    = pushed_q;
        in_flight_d = in_flight_q << 1;
        issue       = 1'b0;
        if (push) pushed_d = pushed_q + CNT_ONE;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    count_d  = word_count;
                    issued_d = '0;
                    pushed_d = '0;
                    if (word_count == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ISSUE;
                        addr_d  = start_addr;
                    end
                end
            end
            ST_ISSUE: begin
                if (issued_q != count_q && credit_ok) begin
                    issue    = 1'b1;
                    issued_d = issued_q + CNT_ONE;
                    addr_d   = addr_step;
                    if (issued_d == count_q) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && out_last) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        in_flight_d[0] = issue;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            count_q     <= '0;
            issued_q    <= '0;
            pushed_q    <= '0;
            in_flight_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            issued_q    <= issued_d;
            pushed_q    <= pushed_d;
            in_flight_q <= in_flight_d;
        end
    end

    r_mem_reader_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock       (clock),
        .reset_n     (reset_n),
        .push_i      (push),
        .push_data_i ({push_last, mem_q}),
        .pop_i       (pop),
        .head_data_o (fifo_head),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

endmodule

// File: tb/tb_r_mem_reader.sv
// Bench for r_mem_reader: ROM model with two-cycle latency, randomized backpressure, expected
// stream computed directly from base/count arithmetic. Honours R_MEM_READER_REVERSE_EN.
module tb_r_mem_reader;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  base_addr = '0;
    logic [7:0]  word_count = '0;
    logic        busy;
    logic        done;
    logic [6:0]  mem_addr;
    logic [31:0] mem_q;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    r_mem_reader dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .mem_addr   (mem_addr),
        .mem_q      (mem_q),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last)
    );

    // ROM: registered address then registered data, word[a] = 0xA5000000 | a.
    logic [6:0] rom_a;
    always @(posedge clock) begin
        rom_a <= mem_addr;
        mem_q <= 32'hA500_0000 | {25'd0, rom_a};
    end

    function automatic logic [32:0] exp_entry(input logic [6:0] b, input logic [7:0] c, input int i);
        logic [6:0] a;
`ifdef R_MEM_READER_REVERSE_EN
        a = 7'(int'(b) + int'(c) - 1 - i);
`else
        a = 7'(int'(b) + i);
`endif
        return {(i == int'(c) - 1), 32'hA500_0000 | {25'd0, a}};
    endfunction

    // Observations from the most recent burst.
    logic [32:0] got_q[$];
    int          first_valid_cyc, last_acc_cyc, done_cyc, done_cnt;
    int          max_out, hold_bad, addr_changes;
    logic [6:0]  pre_addr;
    logic        busy_at_start;

    task automatic run_burst(input logic [6:0] b, input logic [7:0] c, input int ready_pct);
        logic [6:0]  prev_addr;
        logic [31:0] held;
        logic        holding;
        int          accepted;
        got_q.delete();
        first_valid_cyc = -1; last_acc_cyc = -1; done_cyc = -1; done_cnt = 0;
        max_out = 0; hold_bad = 0; addr_changes = 0;
        pre_addr = mem_addr;
        @(negedge clock);
        start = 1'b1; base_addr = b; word_count = c;
        @(posedge clock); #1;
        start = 1'b0;
        busy_at_start = busy;
        prev_addr = (c == 0) ? pre_addr : mem_addr;
        holding = 1'b0;
        accepted = 0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (mem_addr !== prev_addr) begin
                addr_changes++;
                prev_addr = mem_addr;
            end
            if (addr_changes - accepted > max_out) max_out = addr_changes - accepted;
            if (holding && (!out_valid || out_data !== held)) hold_bad++;
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            out_ready = ($urandom_range(99, 0) < ready_pct);
            holding = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    got_q.push_back({out_last, out_data});
                    accepted++;
                    last_acc_cyc = cyc;
                end else begin
                    holding = 1'b1;
                    held = out_data;
                end
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
            @(posedge clock); #1;
        end
        out_ready = 1'b0;
        total++;
        if (done_cyc < 0) begin
            bad++;
            $display("FAIL burst_timeout base=%0d count=%0d: done never seen", b, c);
        end
    endtask

    task automatic test_reset();
        #12;
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0)      begin bad++; $display("FAIL rst_done got=%b want=0", done); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", out_valid); end
        total++; if (out_last !== 1'b0)  begin bad++; $display("FAIL rst_last got=%b want=0", out_last); end
        total++; if (mem_addr !== 7'd0)  begin bad++; $display("FAIL rst_addr got=%0d want=0", mem_addr); end
        total++; if (out_data !== 32'd0) begin bad++; $display("FAIL rst_data got=%h want=0", out_data); end
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(posedge clock);
    endtask

    task automatic test_full_sweep();
        run_burst(7'd0, 8'd128, 100);
        total++; if (got_q.size() != 128) begin bad++; $display("FAIL sweep_count got=%0d want=128", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 128; i++) begin
            total++;
            if (got_q[i] !== exp_entry(7'd0, 8'd128, i)) begin
                bad++; $display("FAIL sweep_word[%0d] got=%h want=%h", i, got_q[i], exp_entry(7'd0, 8'd128, i));
            end
        end
        total++; if (first_valid_cyc != 3) begin bad++; $display("FAIL sweep_latency got=%0d want=3", first_valid_cyc); end
        total++; if (last_acc_cyc - first_valid_cyc != 127) begin bad++; $display("FAIL sweep_bubbles span=%0d want=127", last_acc_cyc - first_valid_cyc); end
        total++; if (done_cyc != last_acc_cyc + 1) begin bad++; $display("FAIL sweep_done_cyc got=%0d want=%0d", done_cyc, last_acc_cyc + 1); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL sweep_done_pulses got=%0d want=1", done_cnt); end
        total++; if (busy_at_start !== 1'b1) begin bad++; $display("FAIL sweep_busy got=%b want=1", busy_at_start); end
        total++; if (busy !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL sweep_idle busy=%b valid=%b want=0/0", busy, out_valid); end
    endtask

    task automatic test_wrap();
        run_burst(7'd126, 8'd4, 100);
        total++; if (got_q.size() != 4) begin bad++; $display("FAIL wrap_count got=%0d want=4", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 4; i++) begin
            total++;
            if (got_q[i] !== exp_entry(7'd126, 8'd4, i)) begin
                bad++; $display("FAIL wrap_word[%0d] got=%h want=%h", i, got_q[i], exp_entry(7'd126, 8'd4, i));
            end
        end
    endtask

    task automatic test_backpressure();
        for (int n = 0; n < 6; n++) begin
            logic [6:0] b;
            logic [7:0] c;
            int         pct;
            b   = 7'($urandom);
            c   = (n == 0) ? 8'd8 : 8'($urandom_range(24, 1));
            pct = (n == 0) ? 50 : int'($urandom_range(90, 30));
            run_burst(b, c, pct);
            total++; if (got_q.size() != int'(c)) begin bad++; $display("FAIL bp%0d_count got=%0d want=%0d", n, got_q.size(), c); end
            for (int i = 0; i < got_q.size() && i < int'(c); i++) begin
                total++;
                if (got_q[i] !== exp_entry(b, c, i)) begin
                    bad++; $display("FAIL bp%0d_word[%0d] got=%h want=%h", n, i, got_q[i], exp_entry(b, c, i));
                end
            end
            total++; if (max_out > 4) begin bad++; $display("FAIL bp%0d_outstanding got=%0d want<=4", n, max_out); end
            total++; if (hold_bad != 0) begin bad++; $display("FAIL bp%0d_hold got=%0d want=0", n, hold_bad); end
            total++; if (first_valid_cyc != 3) begin bad++; $display("FAIL bp%0d_latency got=%0d want=3", n, first_valid_cyc); end
            total++; if (done_cyc != last_acc_cyc + 1) begin bad++; $display("FAIL bp%0d_done got=%0d want=%0d", n, done_cyc, last_acc_cyc + 1); end
        end
    endtask

    task automatic test_zero_count();
        run_burst(7'($urandom), 8'd0, 100);
        total++; if (addr_changes != 0) begin bad++; $display("FAIL zero_addr_moves got=%0d want=0", addr_changes); end
        total++; if (got_q.size() != 0 || first_valid_cyc != -1) begin bad++; $display("FAIL zero_valid words=%0d first=%0d want none", got_q.size(), first_valid_cyc); end
        total++; if (done_cyc != 0) begin bad++; $display("FAIL zero_done_cyc got=%0d want=0", done_cyc); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL zero_done_pulses got=%0d want=1", done_cnt); end
    endtask

    task automatic test_reset_mid_burst();
        int   acc;
        logic found;
        @(negedge clock);
        start = 1'b1; base_addr = 7'($urandom); word_count = 8'd10;
        @(posedge clock); #1;
        start = 1'b0;
        out_ready = 1'b1;
        acc = 0;
        found = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (out_valid && acc == 2) begin
                found = 1'b1;
                break;
            end
            if (out_valid) acc++;
            @(posedge clock); #1;
        end
        total++; if (!found) begin bad++; $display("FAIL midrst_word3 not presented within budget"); end
        reset_n = 1'b0;
        out_ready = 1'b0;
        #1;
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0)      begin bad++; $display("FAIL midrst_done got=%b want=0", done); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", out_valid); end
        total++; if (out_last !== 1'b0)  begin bad++; $display("FAIL midrst_last got=%b want=0", out_last); end
        total++; if (mem_addr !== 7'd0)  begin bad++; $display("FAIL midrst_addr got=%0d want=0", mem_addr); end
        total++; if (out_data !== 32'd0) begin bad++; $display("FAIL midrst_data got=%h want=0", out_data); end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        run_burst(7'd5, 8'd2, 100);
        total++; if (got_q.size() != 2) begin bad++; $display("FAIL midrst_count got=%0d want=2", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 2; i++) begin
            total++;
            if (got_q[i] !== exp_entry(7'd5, 8'd2, i)) begin
                bad++; $display("FAIL midrst_word[%0d] got=%h want=%h", i, got_q[i], exp_entry(7'd5, 8'd2, i));
            end
        end
    endtask

    task automatic test_order_small();
        run_burst(7'd10, 8'd3, 100);
        total++; if (got_q.size() != 3) begin bad++; $display("FAIL order_count got=%0d want=3", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 3; i++) begin
            total++;
            if (got_q[i] !== exp_entry(7'd10, 8'd3, i)) begin
                bad++; $display("FAIL order_word[%0d] got=%h want=%h", i, got_q[i], exp_entry(7'd10, 8'd3, i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_sweep();
        test_wrap();
        test_backpressure();
        test_zero_count();
        test_reset_mid_burst();
        test_order_small();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
